// File: rtl/grahzm8_loader.sv
// grahzm8_loader: framed byte-stream loader for the Grahzm8 program memory.
// Frame: SYNC(A5) BASE LEN payload[LEN] CHK, valid when the byte sum of
// BASE..CHK is zero mod 256. The CPU is held in reset from SYNC until a
// frame verifies.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | hunting for SYNC; other bytes are accepted and dropped
// BASE   | next byte is the start address
// LEN    | next byte is the payload length (0 = 256)
// DATA   | payload bytes are written to memory as they arrive
// CHK    | next byte is the checksum; verdict is taken on its edge
// FIN    | one-cycle verdict slot, input stalled
module grahzm8_loader #(
  parameter int    UUID    = 0,
  parameter string NAME    = "",
  parameter int    TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       prog_we,
  output logic [7:0] prog_addr,
  output logic [7:0] prog_wdata,
  output logic       cpu_hold,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_BASE, S_LEN, S_DATA, S_CHK, S_FIN
  } state_t;

  // The idle counter only has to hold 0..TIMEOUT-1: the edge that would
  // reach TIMEOUT is the timeout itself.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t      state, state_d;
  logic [7:0]  ptr, ptr_d;
  logic [8:0]  cnt, cnt_d;
  logic [7:0]  sum, sum_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic        ready_d, we_d, hold_d, done_d, err_d;
  logic [7:0]  addr_d, wdata_d;
  logic [1:0]  code_d;
  logic        accept, timed;
  logic [7:0]  sum_chk;

  // Identification parameters carry no hardware; keep them referenced.
  logic unused_ident;
  assign unused_ident = (UUID != 0) ^ (NAME != "");

  assign accept  = in_valid & in_ready;
  assign sum_chk = sum + in_data;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    sum_d   = sum;
    tcnt_d  = '0;
    we_d    = 1'b0;
    addr_d  = prog_addr;
    wdata_d = prog_wdata;
    hold_d  = cpu_hold;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code;
    timed   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && in_data == 8'hA5) begin
          state_d = S_BASE;
          code_d  = 2'b00;
          hold_d  = 1'b1;
        end
      end
      S_BASE: begin
        timed = 1'b1;
        if (accept) begin
          ptr_d   = in_data;
          sum_d   = in_data;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        timed = 1'b1;
        if (accept) begin
          cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          sum_d   = sum_chk;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        timed = 1'b1;
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr;
          wdata_d = in_data;
          ptr_d   = ptr + 8'd1;
          sum_d   = sum_chk;
          cnt_d   = cnt - 9'd1;
          if (cnt == 9'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        timed = 1'b1;
        if (accept) begin
          sum_d   = sum_chk;
          state_d = S_FIN;
          // Verdict registered here so it is visible throughout FIN.
          if (sum_chk == 8'h00) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // An accepted byte always clears the counter, so it wins over a
    // timeout falling on the same edge.
    if (timed && !accept && TIMEOUT != 0) begin
      if (tcnt == TLAST) begin
        err_d   = 1'b1;
        code_d  = 2'b10;
        hold_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        tcnt_d = tcnt + TW'(1);
      end
    end
    ready_d = (state_d != S_FIN);
  end

  // State and output registers; reset drops any in-flight write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= 8'h00;
      cnt        <= 9'd0;
      sum        <= 8'h00;
      tcnt       <= '0;
      in_ready   <= 1'b0;
      prog_we    <= 1'b0;
      prog_addr  <= 8'h00;
      prog_wdata <= 8'h00;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      cnt        <= cnt_d;
      sum        <= sum_d;
      tcnt       <= tcnt_d;
      in_ready   <= ready_d;
      prog_we    <= we_d;
      prog_addr  <= addr_d;
      prog_wdata <= wdata_d;
      cpu_hold   <= hold_d;
      done       <= done_d;
      err        <= err_d;
      err_code   <= code_d;
    end
  end

endmodule

// File: tb/tb_grahzm8_loader.sv
// Bench for grahzm8_loader: table of frames plus hand-written timeout and
// reset sequences, then random frames checked against a frame-level model.
module tb_grahzm8_loader;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, prog_we, cpu_hold, done, err;
  logic [7:0] prog_addr, prog_wdata;
  logic [1:0] err_code;

  grahzm8_loader #(.UUID(3), .NAME("ldr"), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int wr_seen = 0, done_seen = 0, err_seen = 0;
  int exp_wr = 0;
  logic       prev_hold = 1'b1;
  logic [1:0] prev_code = 2'b00;
  logic [7:0] pl [256];

  typedef struct {
    logic [7:0] base;
    int         n;
    logic [7:0] start;
    logic [7:0] step;
    logic [7:0] ck;
    int         gap;
    int         garbage;
    logic       exp_ok;
    logic [1:0] exp_code;
  } vec_t;
  vec_t tbl [6];

  // Count strobes/pulses seen on the DUT outputs.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (prog_we) wr_seen++;
      if (done) done_seen++;
      if (err) err_seen++;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send(input logic [7:0] b);
    int w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) cmp("ready_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Reference: checksum that makes BASE+LEN+payload+CHK == 0 mod 256.
  function automatic logic [7:0] model_chk(input logic [7:0] base, input int n);
    int s = base + (n % 256);
    for (int i = 0; i < n; i++) s += pl[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic send_frame(input logic [7:0] base, input int n, input logic [7:0] ck,
                            input int gap, input int garbage,
                            input logic exp_ok, input logic [1:0] exp_code);
    logic [7:0] g, a;
    int d0, e0;
    d0 = done_seen;
    e0 = err_seen;
    cmp("hold_before", 32'(cpu_hold), 32'(prev_hold));
    cmp("code_sticky", 32'(err_code), 32'(prev_code));
    for (int i = 0; i < garbage; i++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h3C;
      send(g);
    end
    send(8'hA5);
    cmp("hold_after_sync", 32'(cpu_hold), 32'd1);
    cmp("code_clear", 32'(err_code), 32'd0);
    idle(gap); send(base);
    idle(gap); send(8'(n));
    for (int i = 0; i < n; i++) begin
      idle(gap);
      send(pl[i]);
      a = 8'(base + 8'(i));
      cmp("we", 32'(prog_we), 32'd1);
      cmp("addr", 32'(prog_addr), 32'(a));
      cmp("wdata", 32'(prog_wdata), 32'(pl[i]));
      exp_wr++;
    end
    idle(gap);
    send(ck);
    cmp("fin_done", 32'(done), 32'(exp_ok));
    cmp("fin_err", 32'(err), 32'(!exp_ok));
    cmp("fin_hold", 32'(cpu_hold), 32'(!exp_ok));
    cmp("fin_ready", 32'(in_ready), 32'd0);
    cmp("fin_code", 32'(err_code), 32'(exp_code));
    @(negedge clk);
    cmp("post_done", 32'(done), 32'd0);
    cmp("post_err", 32'(err), 32'd0);
    cmp("post_ready", 32'(in_ready), 32'd1);
    cmp("write_count", 32'(wr_seen), 32'(exp_wr));
    cmp("done_pulses", 32'(done_seen - d0), 32'(exp_ok));
    cmp("err_pulses", 32'(err_seen - e0), 32'(!exp_ok));
    prev_hold = !exp_ok;
    prev_code = exp_code;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] base, ck;
    int n, e0;
    logic ok;

    tbl[0] = '{8'h10, 3,   8'h01, 8'h01, 8'hE7, 0, 0, 1'b1, 2'b00};
    tbl[1] = '{8'hFE, 3,   8'hAA, 8'h11, 8'hCE, 5, 0, 1'b1, 2'b00};
    tbl[2] = '{8'h10, 3,   8'h01, 8'h01, 8'hE8, 0, 0, 1'b0, 2'b01};
    tbl[3] = '{8'h10, 3,   8'h01, 8'h01, 8'hE7, 0, 0, 1'b1, 2'b00};
    tbl[4] = '{8'h00, 256, 8'h00, 8'h01, 8'h80, 0, 2, 1'b1, 2'b00};
    tbl[5] = '{8'h40, 2,   8'hA5, 8'h00, 8'h74, 1, 1, 1'b1, 2'b00};

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(negedge clk);
    cmp("rst_ready", 32'(in_ready), 32'd0);
    cmp("rst_we", 32'(prog_we), 32'd0);
    cmp("rst_addr", 32'(prog_addr), 32'd0);
    cmp("rst_wdata", 32'(prog_wdata), 32'd0);
    cmp("rst_hold", 32'(cpu_hold), 32'd1);
    cmp("rst_done", 32'(done), 32'd0);
    cmp("rst_err", 32'(err), 32'd0);
    cmp("rst_code", 32'(err_code), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cmp("ready_after_rst", 32'(in_ready), 32'd1);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < tbl[v].n; i++)
        pl[i] = 8'(tbl[v].start + tbl[v].step * 8'(i));
      send_frame(tbl[v].base, tbl[v].n, tbl[v].ck, tbl[v].gap, tbl[v].garbage,
                 tbl[v].exp_ok, tbl[v].exp_code);
    end

    // Timeout after one payload byte of a two-byte frame.
    e0 = err_seen;
    send(8'hA5); send(8'h20); send(8'h02); send(8'h11);
    cmp("to_we", 32'(prog_we), 32'd1);
    cmp("to_addr", 32'(prog_addr), 32'h20);
    cmp("to_wdata", 32'(prog_wdata), 32'h11);
    exp_wr++;
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      cmp("to_err", 32'(err), 32'(k == T));
    end
    cmp("to_code", 32'(err_code), 32'd2);
    cmp("to_hold", 32'(cpu_hold), 32'd1);
    cmp("to_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    cmp("to_err_pulse", 32'(err), 32'd0);
    send(8'h00);
    idle(3);
    cmp("to_discard", 32'(wr_seen), 32'(exp_wr));
    cmp("to_err_count", 32'(err_seen - e0), 32'd1);
    prev_hold = 1'b1;
    prev_code = 2'b10;

    // A byte landing on the would-be timeout edge wins.
    cmp("bw_code_sticky", 32'(err_code), 32'd2);
    e0 = err_seen;
    send(8'hA5); send(8'h30); send(8'h01);
    idle(T - 1);
    send(8'h77);
    cmp("bw_we", 32'(prog_we), 32'd1);
    cmp("bw_addr", 32'(prog_addr), 32'h30);
    cmp("bw_wdata", 32'(prog_wdata), 32'h77);
    exp_wr++;
    idle(T - 1);
    send(8'h58);
    cmp("bw_done", 32'(done), 32'd1);
    cmp("bw_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    cmp("bw_no_err", 32'(err_seen - e0), 32'd0);
    prev_hold = 1'b0;
    prev_code = 2'b00;

    // Reset in the middle of the payload.
    send(8'hA5); send(8'h50); send(8'h04); send(8'h01); send(8'h02);
    cmp("mr_we", 32'(prog_we), 32'd1);
    exp_wr += 2;
    #2 rst = 1'b0;
    #1;
    cmp("mr_we_drop", 32'(prog_we), 32'd0);
    cmp("mr_hold", 32'(cpu_hold), 32'd1);
    cmp("mr_ready", 32'(in_ready), 32'd0);
    cmp("mr_addr", 32'(prog_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cmp("mr_ready_back", 32'(in_ready), 32'd1);
    cmp("mr_write_count", 32'(wr_seen), 32'(exp_wr));
    prev_hold = 1'b1;
    prev_code = 2'b00;
    for (int i = 0; i < 4; i++) pl[i] = 8'(8'h91 + 8'(i));
    send_frame(8'h60, 4, model_chk(8'h60, 4), 0, 0, 1'b1, 2'b00);

    // Random frames against the frame-level model.
    for (int r = 0; r < 30; r++) begin
      base = 8'($urandom);
      n = (r % 10 == 9) ? int'($urandom_range(200, 256)) : int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
      ck = model_chk(base, n);
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      ok = (model_chk(base, n) == ck);
      send_frame(base, n, ck, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 ok, ok ? 2'b00 : 2'b01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
